// File: rtl/decade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decade_pkg
//  Description : Shared constants and helper functions for the BCD decade
//                down-counter family.
//                  BCD_W       - bits per BCD digit
//                  DIGIT_MAX   - largest legal BCD digit (9)
//                  DIGIT_MIN   - smallest BCD digit (0)
//                  MAX_DIGITS  - widest counter the helpers accept
//                  bcd_clamp   - min(digit, 9)
//                  bcd_is_zero - all-zero test on a (zero-extended) vector
//  Revision    : 1.0 - initial release
// ============================================================================
package decade_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] DIGIT_MIN  = 4'd0;
    localparam int         MAX_DIGITS = 16;

    // Saturate a 4-bit code into the legal BCD range.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
        return (digit > DIGIT_MAX) ? DIGIT_MAX : digit;
    endfunction

    // Callers zero-extend their DIGITS-wide count to the full helper width.
    function automatic logic bcd_is_zero(input logic [BCD_W*MAX_DIGITS-1:0] vec);
        return (vec == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_dn.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_dn
//  Description : One BCD digit of a decade down-counter.
//                  clk, rst    - clock, synchronous active-high reset
//                  ld, ld_val  - parallel load (ld_val must already be legal)
//                  dec         - decrement this digit
//                  q           - current digit value
//                  borrow_out  - dec & (q == 0); drives the next digit's dec
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_dn
    import decade_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= DIGIT_MIN;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (dec) begin
            r_q <= (r_q == DIGIT_MIN) ? DIGIT_MAX : (r_q - 4'd1);
        end
    end

    assign q          = r_q;
    assign borrow_out = dec & (r_q == DIGIT_MIN);

endmodule
`default_nettype wire

// File: rtl/decade_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : decade_down_counter
//  Description : Multi-digit BCD down-counter with parallel load, enable,
//                borrow chaining, wrap / one-shot mode and status flags.
//                  clk, rst    - clock, synchronous active-high reset
//                  load        - parallel load strobe (highest after rst)
//                  load_val    - BCD load value, digit 0 in [3:0]
//                  en, bin     - count enable and borrow-in
//                  cnt         - registered BCD count
//                  bout        - combinational borrow-out for cascading
//                  zero        - registered, cnt == 0
//                  done        - registered, one-shot mode holding at zero
//                  wrap_pulse  - registered, one cycle after 0 -> all nines
//                  load_err    - registered, last load had a digit > 9
//  Revision    : 1.0 - initial release
// ============================================================================
module decade_down_counter
    import decade_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  bin,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  bout,
    output logic                  zero,
    output logic                  done,
    output logic                  wrap_pulse,
    output logic                  load_err
);

    localparam int c_w     = BCD_W * DIGITS;
    localparam int c_ext_w = BCD_W * MAX_DIGITS;

    logic [c_w-1:0]     w_ld_val;
    logic               w_ld_bad;
    logic [c_ext_w-1:0] w_cnt_ext;
    logic               w_cnt_zero;
    logic               w_cnt_one;
    logic               w_count_evt;
    logic               w_dec;
    logic [DIGITS:0]    w_dec_chain;

    logic r_zero;
    logic r_done;
    logic r_wrap_pulse;
    logic r_load_err;

    // Clamp every incoming digit and flag any that was out of range.
    always_comb begin
        w_ld_val = '0;
        w_ld_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_ld_val[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
            if (load_val[i*BCD_W +: BCD_W] > DIGIT_MAX) begin
                w_ld_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_ext        = '0;
        w_cnt_ext[c_w-1:0] = cnt;
    end

    assign w_cnt_zero  = bcd_is_zero(w_cnt_ext);
    assign w_cnt_one   = (w_cnt_ext == c_ext_w'(1));
    assign w_count_evt = en & bin & ~load & ~r_done;
    // In one-shot mode a count event at zero only sets done; cnt must not move.
    assign w_dec       = w_count_evt & (WRAP | ~w_cnt_zero);

    assign w_dec_chain[0] = w_dec;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit_dn u_digit (
                .clk        (clk),
                .rst        (rst),
                .ld         (load),
                .ld_val     (w_ld_val[k*BCD_W +: BCD_W]),
                .dec        (w_dec_chain[k]),
                .q          (cnt[k*BCD_W +: BCD_W]),
                .borrow_out (w_dec_chain[k+1])
            );
        end
    endgenerate

    // A borrow leaving the top digit means the whole count went 0 -> all nines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero       <= 1'b1;
            r_done       <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_wrap_pulse <= w_dec_chain[DIGITS];
            if (load) begin
                r_zero     <= (w_ld_val == '0);
                r_done     <= 1'b0;
                r_load_err <= w_ld_bad;
            end else if (w_dec) begin
                // Next count is zero only when stepping down from one.
                r_zero <= w_cnt_one;
            end else if (!WRAP && w_count_evt && w_cnt_zero) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bout       = en & bin & w_cnt_zero & (WRAP | ~r_done);
    assign zero       = r_zero;
    assign done       = r_done;
    assign wrap_pulse = r_wrap_pulse;
    assign load_err   = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_decade_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decade_down_counter
//  Description : Scoreboard bench. Four counters run in parallel: a wrapping
//                counter, a one-shot counter (same stimulus) and a two-stage
//                wrapping cascade. An integer-valued model predicts each
//                cycle's outputs; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decade_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, en, bin, load_lo, load_hi;
    logic [15:0] load_val, load_val_lo, load_val_hi;

    logic [15:0] cnt_w, cnt_o, cnt_lo, cnt_hi;
    logic bout_w, zero_w, done_w, wp_w, err_w;
    logic bout_o, zero_o, done_o, wp_o, err_o;
    logic bout_lo, zero_lo, done_lo, wp_lo, err_lo;
    logic bout_hi, zero_hi, done_hi, wp_hi, err_hi;

    decade_down_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .bin(bin),
        .cnt(cnt_w), .bout(bout_w), .zero(zero_w), .done(done_w),
        .wrap_pulse(wp_w), .load_err(err_w));

    decade_down_counter #(.DIGITS(4), .WRAP(1'b0)) u_oneshot (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .bin(bin),
        .cnt(cnt_o), .bout(bout_o), .zero(zero_o), .done(done_o),
        .wrap_pulse(wp_o), .load_err(err_o));

    decade_down_counter #(.DIGITS(4), .WRAP(1'b1)) u_lo (
        .clk(clk), .rst(rst), .load(load_lo), .load_val(load_val_lo), .en(en), .bin(1'b1),
        .cnt(cnt_lo), .bout(bout_lo), .zero(zero_lo), .done(done_lo),
        .wrap_pulse(wp_lo), .load_err(err_lo));

    decade_down_counter #(.DIGITS(4), .WRAP(1'b1)) u_hi (
        .clk(clk), .rst(rst), .load(load_hi), .load_val(load_val_hi), .en(en), .bin(bout_lo),
        .cnt(cnt_hi), .bout(bout_hi), .zero(zero_hi), .done(done_hi),
        .wrap_pulse(wp_hi), .load_err(err_hi));

    // ---------------- reference model (integer value per counter) ----------
    typedef struct packed {
        logic [15:0] cnt;
        logic        zero;
        logic        done;
        logic        wp;
        logic        err;
        logic        bout;
    } exp_t;
    typedef exp_t [3:0] rec_t;

    typedef struct {
        int v;
        bit done;
        bit wp;
        bit err;
    } mst_t;

    mst_t m [4];
    bit   m_wrap [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit   m_known = 1'b0;
    rec_t exp_q [$];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mst_t step(input mst_t s, input bit wrap, input bit r,
                                  input bit ld, input logic [15:0] lv, input bit evt);
        mst_t n;
        int   d;
        n    = s;
        n.wp = 1'b0;
        if (r) begin
            n.v = 0; n.done = 1'b0; n.err = 1'b0;
        end else if (ld) begin
            n.v = 0; n.err = 1'b0; n.done = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                d = int'(lv[i*4 +: 4]);
                if (d > 9) begin
                    d = 9; n.err = 1'b1;
                end
                n.v = n.v * 10 + d;
            end
        end else if (evt && !s.done) begin
            if (s.v > 0)   n.v = s.v - 1;
            else if (wrap) begin n.v = 9999; n.wp = 1'b1; end
            else           n.done = 1'b1;
        end
        return n;
    endfunction

    function automatic exp_t mk(input mst_t s, input bit wrap, input bit en_bin);
        exp_t e;
        e.cnt  = to_bcd(s.v);
        e.zero = (s.v == 0);
        e.done = s.done;
        e.wp   = s.wp;
        e.err  = s.err;
        e.bout = en_bin && (s.v == 0) && (wrap || !s.done);
        return e;
    endfunction

    // One clock of stimulus: drive, predict this cycle's outputs, advance model.
    task automatic cyc(input bit r, input bit la, input logic [15:0] va,
                       input bit e, input bit b,
                       input bit llo = 1'b0, input logic [15:0] vlo = 16'h0,
                       input bit lhi = 1'b0, input logic [15:0] vhi = 16'h0);
        rec_t rec;
        bit   hi_bin;
        rst = r; load = la; load_val = va; en = e; bin = b;
        load_lo = llo; load_val_lo = vlo; load_hi = lhi; load_val_hi = vhi;
        hi_bin = e && (m[2].v == 0);
        rec[0] = mk(m[0], m_wrap[0], e && b);
        rec[1] = mk(m[1], m_wrap[1], e && b);
        rec[2] = mk(m[2], m_wrap[2], e);
        rec[3] = mk(m[3], m_wrap[3], hi_bin);
        if (m_known) exp_q.push_back(rec);
        @(posedge clk);
        m[0] = step(m[0], m_wrap[0], r, la,  va,  e && b);
        m[1] = step(m[1], m_wrap[1], r, la,  va,  e && b);
        m[2] = step(m[2], m_wrap[2], r, llo, vlo, e);
        m[3] = step(m[3], m_wrap[3], r, lhi, vhi, hi_bin);
        if (r) m_known = 1'b1;
        #1;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input int inst, input string name, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            rec_t a;
            e = exp_q.pop_front();
            a[0] = '{cnt_w,  zero_w,  done_w,  wp_w,  err_w,  bout_w};
            a[1] = '{cnt_o,  zero_o,  done_o,  wp_o,  err_o,  bout_o};
            a[2] = '{cnt_lo, zero_lo, done_lo, wp_lo, err_lo, bout_lo};
            a[3] = '{cnt_hi, zero_hi, done_hi, wp_hi, err_hi, bout_hi};
            for (int i = 0; i < 4; i++) begin
                chk(i, "cnt",        a[i].cnt,          e[i].cnt);
                chk(i, "zero",       16'(a[i].zero),    16'(e[i].zero));
                chk(i, "done",       16'(a[i].done),    16'(e[i].done));
                chk(i, "wrap_pulse", 16'(a[i].wp),      16'(e[i].wp));
                chk(i, "load_err",   16'(a[i].err),     16'(e[i].err));
                chk(i, "bout",       16'(a[i].bout),    16'(e[i].bout));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rand_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return to_bcd(int'($urandom_range(0, 12)));
    endfunction

    initial begin
        // Reset then idle.
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Borrow ripple across two digits.
        cyc(0, 1, 16'h0103, 0, 1);
        repeat (4) cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        // 0001 -> 0000 -> wrap (one-shot copy goes done and holds).
        cyc(0, 1, 16'h0001, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // One-shot countdown from 0002, then reload.
        cyc(0, 1, 16'h0002, 0, 1);
        repeat (5) cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 16'h0005, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Load clamping, error flag, load beats count.
        cyc(0, 1, 16'hA3F7, 0, 1);
        cyc(0, 1, 16'h1234, 0, 1);
        cyc(0, 1, 16'h1234, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        // Cascade: lower at 0000, upper at 0005, then mid-count reset.
        cyc(0, 0, 0, 0, 1, 1, 16'h0000, 1, 16'h0005);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 10), rand_val(),
                ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 85),
                ($urandom_range(0, 99) < 5), rand_val(),
                ($urandom_range(0, 99) < 3), rand_val());
        end
        cyc(0, 0, 0, 0, 1);
        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
